// File: rtl/mem_access_ctrl_if.sv
// mem_access_ctrl_if: command, write/read stream and memory-bus signals of the block-transfer controller.
// slave is the controller side, master is the requester/memory side.
interface mem_access_ctrl_if #(
    parameter int DW = 16,
    parameter int AW = 8
);
    logic          start;
    logic          op;
    logic [AW-1:0] base_addr;
    logic [AW-1:0] length;
    logic [DW-1:0] wr_data;
    logic          wr_valid;
    logic          wr_ready;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic          busy;
    logic          done;
    logic          err;
    logic          mem_en;
    logic          mem_r_w;
    logic [AW-1:0] mem_abus;
    logic [DW-1:0] mem_dout;
    logic [DW-1:0] mem_din;
    logic          mem_stored;

    modport slave (
        input  start, op, base_addr, length, wr_data, wr_valid, mem_din, mem_stored,
        output wr_ready, rd_data, rd_valid, busy, done, err, mem_en, mem_r_w, mem_abus, mem_dout
    );
    modport master (
        output start, op, base_addr, length, wr_data, wr_valid, mem_din, mem_stored,
        input  wr_ready, rd_data, rd_valid, busy, done, err, mem_en, mem_r_w, mem_abus, mem_dout
    );
endinterface

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: block write/read controller between a word stream and a registered single-port memory.
// All outputs are registered; commands are range-checked against DEPTH before any memory access.
module mem_access_ctrl #(
    parameter int DW    = 16,
    parameter int AW    = 8,
    parameter int DEPTH = 128
) (
    input logic               clk_i,
    input logic               rst_n_i,
    mem_access_ctrl_if.slave  bus
);
    typedef enum logic [2:0] {IDLE, WRITE, WACK, READ, DRAIN, FIN} state_t;

    state_t        state_q;
    logic          op_q;
    logic [AW-1:0] base_q, len_q, cnt_q, abus_q;
    logic [DW-1:0] dout_q, rd_data_q;
    logic          wr_ready_q, rd_pend_q, rd_valid_q, busy_q, done_q, err_q, mem_en_q, mem_r_w_q;
    logic [AW:0]   end_d;
    logic          last_d;

    assign end_d  = {1'b0, bus.base_addr} + {1'b0, bus.length};
    assign last_d = (cnt_q + AW'(1)) == len_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= IDLE;
            op_q       <= 1'b0;
            base_q     <= '0;
            len_q      <= '0;
            cnt_q      <= '0;
            abus_q     <= '0;
            dout_q     <= '0;
            rd_data_q  <= '0;
            wr_ready_q <= 1'b0;
            rd_pend_q  <= 1'b0;
            rd_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            mem_en_q   <= 1'b0;
            mem_r_w_q  <= 1'b0;
        end else begin
            mem_en_q   <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            // memory output is registered: data for a read issued in c is captured at the end of c+1
            rd_pend_q  <= mem_en_q & mem_r_w_q;
            rd_valid_q <= rd_pend_q;
            if (rd_pend_q) rd_data_q <= bus.mem_din;
            case (state_q)
                IDLE: if (bus.start) begin
                    op_q   <= bus.op;
                    base_q <= bus.base_addr;
                    len_q  <= bus.length;
                    cnt_q  <= '0;
                    busy_q <= 1'b1;
                    if (end_d > (AW+1)'(DEPTH)) begin
                        state_q <= FIN;
                        done_q  <= 1'b1;
                        err_q   <= 1'b1;
                    end else if (bus.length == '0) begin
                        state_q <= FIN;
                        done_q  <= 1'b1;
                    end else if (bus.op) begin
                        state_q <= READ;
                    end else begin
                        state_q    <= WRITE;
                        wr_ready_q <= 1'b1;
                    end
                end
                WRITE: if (bus.wr_valid) begin
                    mem_en_q  <= 1'b1;
                    mem_r_w_q <= 1'b0;
                    abus_q    <= base_q + cnt_q;
                    dout_q    <= bus.wr_data;
                    cnt_q     <= cnt_q + AW'(1);
                    if (last_d) begin
                        wr_ready_q <= 1'b0;
                        state_q    <= WACK;
                    end
                end
                // while the last write is still on the bus, mem_stored belongs to the previous word
                WACK: if (!mem_en_q && bus.mem_stored) begin
                    state_q <= FIN;
                    done_q  <= 1'b1;
                end
                READ: begin
                    mem_en_q  <= 1'b1;
                    mem_r_w_q <= 1'b1;
                    abus_q    <= base_q + cnt_q;
                    cnt_q     <= cnt_q + AW'(1);
                    if (last_d) state_q <= DRAIN;
                end
                DRAIN: if (!mem_en_q && !rd_pend_q && rd_valid_q) begin
                    state_q <= FIN;
                    done_q  <= 1'b1;
                end
                FIN: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.wr_ready = wr_ready_q;
    assign bus.rd_data  = rd_data_q;
    assign bus.rd_valid = rd_valid_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.err      = err_q;
    assign bus.mem_en   = mem_en_q;
    assign bus.mem_r_w  = mem_r_w_q;
    assign bus.mem_abus = abus_q;
    assign bus.mem_dout = dout_q;
endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: randomized and directed block transfers checked against a word-level memory model.
module tb_mem_access_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0, bad = 0, cyc = 0, err_cnt = 0;

    mem_access_ctrl_if #(.DW(16), .AW(8)) bus();
    mem_access_ctrl #(.DW(16), .AW(8), .DEPTH(128)) dut (.clk_i(clk), .rst_n_i(rst_n), .bus(bus));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] init_val(input int a);
        return 16'((a * 40503) ^ 23130);
    endfunction

    logic [15:0] mem [256];
    bit          mem_ready;
    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int a = 0; a < 256; a++) mem[a] <= init_val(a);
            mem_ready      <= 1'b1;
            bus.mem_stored <= 1'b0;
            bus.mem_din    <= '0;
        end else begin
            bus.mem_stored <= bus.mem_en && !bus.mem_r_w;
            if (bus.mem_en && bus.mem_r_w) bus.mem_din <= mem[bus.mem_abus];
            if (bus.mem_en && !bus.mem_r_w) mem[bus.mem_abus] <= bus.mem_dout;
        end
    end

    int wr_addr_q[$], wr_data_q[$], wr_cyc_q[$], rd_addr_q[$], rd_cyc_q[$], rv_data_q[$], rv_cyc_q[$];
    int done_cyc_q[$], done_err_q[$], done_busy_q[$];
    always @(negedge clk) if (rst_n) begin
        if (bus.mem_en && !bus.mem_r_w) begin
            wr_addr_q.push_back(int'(bus.mem_abus));
            wr_data_q.push_back(int'(bus.mem_dout));
            wr_cyc_q.push_back(cyc);
        end
        if (bus.mem_en && bus.mem_r_w) begin
            rd_addr_q.push_back(int'(bus.mem_abus));
            rd_cyc_q.push_back(cyc);
        end
        if (bus.rd_valid) begin
            rv_data_q.push_back(int'(bus.rd_data));
            rv_cyc_q.push_back(cyc);
        end
        if (bus.done) begin
            done_cyc_q.push_back(cyc);
            done_err_q.push_back(int'(bus.err));
            done_busy_q.push_back(int'(bus.busy));
        end
        if (bus.err) err_cnt++;
    end

    logic [15:0] ref_mem [256];
    logic [15:0] wdata [256];
    int pat [7] = '{1, 0, 0, 1, 1, 0, 1};

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_ctrl"}, {bus.wr_ready, bus.rd_valid, bus.busy, bus.done, bus.err, bus.mem_en, bus.mem_r_w}, 0);
        check({tag, "_abus"}, bus.mem_abus, 0);
        check({tag, "_dout"}, bus.mem_dout, 0);
        check({tag, "_rdata"}, bus.rd_data, 0);
    endtask

    task automatic clear_mon();
        wr_addr_q.delete(); wr_data_q.delete(); wr_cyc_q.delete();
        rd_addr_q.delete(); rd_cyc_q.delete(); rv_data_q.delete(); rv_cyc_q.delete();
        done_cyc_q.delete(); done_err_q.delete(); done_busy_q.delete();
        err_cnt = 0;
    endtask

    task automatic run_cmd(input bit op, input int base, input int len, input int vmode, input bit inj);
        int  sent = 0;
        int  exp_wcyc[$];
        bit  exp_err = (base + len) > 128;
        @(posedge clk); #1;
        for (int i = 0; i < 300 && bus.busy; i++) begin @(posedge clk); #1; end
        clear_mon();
        bus.start = 1'b1; bus.op = op; bus.base_addr = 8'(base); bus.length = 8'(len);
        @(posedge clk); #1;
        for (int c = 0; c < 2000 && done_cyc_q.size() == 0; c++) begin
            if (!op && sent < len) begin
                bus.wr_valid = vmode == 1 ? 1'b1 : vmode == 2 ? pat[c % 7] != 0 : 1'($urandom_range(0, 1));
                bus.wr_data  = wdata[sent];
                if (bus.wr_valid && bus.wr_ready) begin
                    exp_wcyc.push_back(cyc + 1);
                    sent++;
                end
            end else begin
                bus.wr_valid = op ? 1'($urandom_range(0, 1)) : 1'b0;
                bus.wr_data  = 16'($urandom);
            end
            bus.start = inj && c == 1;
            if (bus.start) begin
                bus.op = ~op; bus.base_addr = 8'($urandom); bus.length = 8'($urandom);
            end
            @(posedge clk); #1;
        end
        bus.start = 1'b0; bus.wr_valid = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        check("done_count", done_cyc_q.size(), 1);
        check("err_pulses", err_cnt, exp_err);
        check("idle_after", bus.busy, 0);
        if (done_cyc_q.size() > 0) begin
            check("err_at_done", done_err_q[0], exp_err);
            check("busy_at_done", done_busy_q[0], 1);
        end
        if (exp_err || len == 0) begin
            check("no_mem_en", wr_addr_q.size() + rd_addr_q.size(), 0);
        end else if (!op) begin
            check("wr_count", wr_addr_q.size(), len);
            check("rd_in_write", rd_addr_q.size(), 0);
            for (int i = 0; i < wr_addr_q.size() && i < len; i++) begin
                check("wr_addr", wr_addr_q[i], base + i);
                check("wr_data", wr_data_q[i], wdata[i]);
                if (i < exp_wcyc.size()) check("wr_cycle", wr_cyc_q[i], exp_wcyc[i]);
            end
            for (int i = 0; i < len; i++) ref_mem[base + i] = wdata[i];
            if (wr_cyc_q.size() > 0 && done_cyc_q.size() > 0)
                check("wr_done_lat", done_cyc_q[0] - wr_cyc_q[$], 2);
        end else begin
            check("rd_issue_count", rd_addr_q.size(), len);
            check("wr_in_read", wr_addr_q.size(), 0);
            check("rv_count", rv_data_q.size(), len);
            for (int i = 0; i < rd_addr_q.size() && i < len; i++) begin
                check("rd_addr", rd_addr_q[i], base + i);
                if (i > 0) check("rd_issue_gap", rd_cyc_q[i] - rd_cyc_q[i-1], 1);
            end
            for (int i = 0; i < rv_data_q.size() && i < len; i++) begin
                check("rd_data", rv_data_q[i], ref_mem[base + i]);
                if (rd_cyc_q.size() > 0) check("rv_cycle", rv_cyc_q[i] - rd_cyc_q[0], i + 2);
            end
            if (rv_cyc_q.size() > 0 && done_cyc_q.size() > 0)
                check("rd_done_lat", done_cyc_q[0] - rv_cyc_q[$], 1);
        end
    endtask

    task automatic fill_rand(input int len);
        for (int i = 0; i < len; i++) wdata[i] = 16'($urandom);
    endtask

    initial begin
        bus.start = 1'b0; bus.op = 1'b0; bus.base_addr = '0; bus.length = '0;
        bus.wr_data = '0; bus.wr_valid = 1'b0;
        for (int a = 0; a < 256; a++) ref_mem[a] = init_val(a);
        repeat (3) @(posedge clk);
        #2;
        check_quiet("reset");
        @(negedge clk) rst_n = 1'b1;

        for (int i = 0; i < 4; i++) wdata[i] = 16'hA000 + 16'(i);
        run_cmd(0, 16, 4, 1, 0);
        run_cmd(1, 16, 4, 1, 0);
        fill_rand(4);   run_cmd(0, 32, 4, 2, 0);
        run_cmd(1, 32, 4, 0, 0);
        fill_rand(3);   run_cmd(0, 126, 3, 1, 0);
        fill_rand(3);   run_cmd(0, 125, 3, 1, 0);
        run_cmd(1, 125, 3, 1, 0);
        run_cmd(0, 50, 0, 1, 0);
        fill_rand(5);   run_cmd(0, 64, 5, 0, 1);
        run_cmd(1, 64, 5, 0, 1);
        fill_rand(128); run_cmd(0, 0, 128, 1, 0);
        run_cmd(1, 120, 8, 0, 0);
        run_cmd(1, 121, 8, 0, 0);
        run_cmd(1, 0, 200, 0, 0);

        @(posedge clk); #1;
        clear_mon();
        bus.start = 1'b1; bus.op = 1'b1; bus.base_addr = 8'd40; bus.length = 8'd6;
        @(posedge clk); #1;
        bus.start = 1'b0;
        for (int i = 0; i < 50 && rd_addr_q.size() < 3; i++) @(negedge clk);
        check("abort_reached", rd_addr_q.size(), 3);
        #2 rst_n = 1'b0;
        #1 check_quiet("abort");
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        fill_rand(6);   run_cmd(0, 40, 6, 0, 0);
        run_cmd(1, 40, 6, 0, 0);

        for (int n = 0; n < 30; n++) begin
            int base = $urandom_range(0, 135);
            int len  = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 200) : $urandom_range(0, 24);
            fill_rand(len);
            run_cmd(1'($urandom_range(0, 1)), base, len, $urandom_range(0, 2), 1'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 Parameters: DW 16, data width; AW 8, address width; DEPTH 128, number of usable words, addresses 0..127.
REQ-002 clk  in  1  single clock; all state changes on posedge clk.
REQ-003 reset  in  1  asynchronous, active-low; reset==0 forces reset state immediately.
REQ-004 start  in  1  one-cycle command strobe, sampled only in IDLE.
REQ-005 op  in  1  0 = block write, 1 = block read; captured with start.
REQ-006 base_addr  in  AW  first word address; captured with start.
REQ-007 length  in  AW  word count, 0..128; captured with start.
REQ-008 wr_data  in  DW  write-stream word.
REQ-009 wr_valid  in  1  wr_data valid.
REQ-010 wr_ready  out  1  controller accepts wr_data this cycle.
REQ-011 rd_data  out  DW  read-stream word, registered.
REQ-012 rd_valid  out  1  rd_data valid for one cycle; no backpressure.
REQ-013 busy  out  1  high in every state except IDLE.
REQ-014 done  out  1  one-cycle completion pulse.
REQ-015 err  out  1  one-cycle range-error pulse, coincident with done.
REQ-016 mem_en  out  1  memory enable, registered.
REQ-017 mem_r_w  out  1  0 = write, 1 = read, registered.
REQ-018 mem_abus  out  AW  memory address, registered.
REQ-019 mem_dout  out  DW  write data to memory input bus, registered.
REQ-020 mem_din  in  DW  memory registered output bus.
REQ-021 mem_stored  in  1  memory write acknowledge; high the cycle after a write-enabled cycle.

Function
REQ-022 States: IDLE, WRITE, WACK, READ, DRAIN, FIN; all outputs are registered.
REQ-023 IDLE + start: capture op, base_addr, length; clear count; go to FIN with err=1 if base_addr+length > DEPTH (9-bit sum); go to FIN with err=0 if length==0; otherwise go to WRITE (op=0) or READ (op=1).
REQ-024 start outside IDLE is ignored; captured fields do not change until FIN.
REQ-025 WRITE: wr_ready=1 while count<length; a word transfers in any cycle k with wr_valid&wr_ready.
REQ-026 A transfer in cycle k drives mem_en=1, mem_r_w=0, mem_abus=base_addr+count, mem_dout=wr_data in cycle k+1; count increments; cycles without transfer drive mem_en=0.
REQ-027 After the last transfer, wr_ready=0 and the state goes to WACK; WACK goes to FIN in the cycle mem_stored==1 is sampled.
REQ-028 READ: one read per cycle, mem_en=1, mem_r_w=1, mem_abus=base_addr+i for i=0..length-1 on consecutive cycles, then DRAIN.
REQ-029 A read issued in cycle c produces rd_data=mem_din sampled at end of c+1, with rd_valid=1 in cycle c+2.
REQ-030 DRAIN holds mem_en=0 until the last rd_valid, then goes to FIN.
REQ-031 FIN lasts one cycle: done=1, err as decided at start, busy=1; next state IDLE.
REQ-032 Memory idle: mem_en=0 in every cycle not listed above; mem_r_w, mem_abus, mem_dout hold their last values.
REQ-033 Address arithmetic is AW bits wide and never wraps past DEPTH-1, guaranteed by the REQ-023 range check; base_addr+length==128 is legal.
REQ-034 wr_valid is ignored outside WRITE; wr_data is not consumed when wr_ready==0.

Reset
REQ-035 reset==0 at any time, including mid-burst, returns to IDLE immediately.
REQ-036 Under reset: wr_ready, rd_valid, busy, done, err, mem_en = 0; mem_r_w = 0; mem_abus, mem_dout, rd_data = 0; count = 0.
REQ-037 After reset release, the first start is accepted no earlier than the first posedge with reset==1.

Verification
REQ-038 Write burst: base_addr=8'h10, length=4, wr_valid continuous, data 16'hA000..A003 -> mem_en/r_w=0 with abus 10..13 on 4 consecutive cycles; done one cycle after mem_stored sampled; err=0.
REQ-039 Read burst: base_addr=8'h10, length=4 after REQ-038 -> rd_valid on 4 consecutive cycles with A000..A003, first rd_valid 2 cycles after the first mem_en; done the cycle after the last rd_valid.
REQ-040 Stalled write: wr_valid toggles 1,0,0,1,1,0,1 with length=4 -> exactly 4 memory writes, mem_en=0 during gaps, addresses contiguous.
REQ-041 Range: base_addr=126, length=3 -> no mem_en, done=1 and err=1 in the same cycle; base_addr=125, length=3 -> normal completion with err=0.
REQ-042 length=0 -> done pulse, err=0, no mem_en; start asserted while busy -> ignored, no command change.
REQ-043 Reset asserted during the third word of a 6-word read -> all outputs 0 asynchronously; a new write after release completes normally.
